mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Shares one W-bit output channel among four requesters by sequencing the select of a 4:1 data mux.
- Round-robin arbitration with a burst-hold grant: the winner keeps the mux until its LAST beat, a forced release after MAX_BURST beats, or an idle timeout.
- Sits between four producer ports and a single valid/ready consumer.

Parameters:
- W, 8, data width of each input and of DOUT.
- MAX_BURST, 16, max beats per grant before forced release (>=1).
- IDLE_TIMEOUT, 8, consecutive cycles the granted REQ may stay low before the grant is revoked (>=1).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  4  per-requester valid/request; REQ[i] high = DINi holds a beat.
- LAST  in  4  per-requester end-of-burst flag, qualified by REQ[i].
- DIN0..DIN3  in  W each  requester data.
- GNT  out  4  one-hot grant, registered.
- SEL  out  2  mux select, registered; equals encode(GNT) while granted.
- DOUT  out  W  combinational mux of DIN0..3 by SEL.
- DOUT_VALID  out  1  = granted & REQ[SEL].
- DOUT_LAST  out  1  = DOUT_VALID & (LAST[SEL] | beat_cnt==MAX_BURST-1).
- DOUT_READY  in  1  consumer accept.
- BUSY  out  1  high in GRANT state.

Behaviour:
- Reset: state IDLE; GNT=0, SEL=0, BUSY=0, DOUT_VALID=0, DOUT_LAST=0, ptr=0, beat_cnt=0, idle_cnt=0. DOUT then shows DIN0 and is don't-care while DOUT_VALID=0.
- FSM states:
  - IDLE: if REQ!=0, pick the first i with REQ[i]=1 scanning ptr, ptr+1, ..., ptr+3 (mod 4). Register GNT=onehot(i), SEL=i, go to GRANT.
  - GRANT: otherwise. If REQ==0, stay in IDLE.
- Arbitration latency: REQ sampled in cycle N gives GNT/SEL valid in cycle N+1. No combinational path from REQ to GNT.
- Beat transfer: a beat moves when DOUT_VALID & DOUT_READY. beat_cnt increments per transfer and clears on leaving GRANT.
- Release condition: a transfer with DOUT_LAST=1.
  - On release: next state IDLE, GNT=0, ptr=SEL+1 (wrap 3->0).
  - One idle cycle always follows a release. Re-arbitration occurs in that IDLE cycle.
- Forced release: beat_cnt reaching MAX_BURST-1 raises DOUT_LAST even if LAST[SEL]=0. LAST and forced release together produce a single release.
- Idle timeout:
  - In GRANT, idle_cnt increments each cycle REQ[SEL]=0 and clears on any cycle REQ[SEL]=1.
  - When idle_cnt reaches IDLE_TIMEOUT-1 with REQ[SEL]=0, revoke: IDLE, ptr=SEL+1, no beat transferred.
- REQ of non-granted requesters is ignored in GRANT and has no effect on DOUT.
- DOUT_READY low stalls the transfer. DOUT, DOUT_VALID and SEL stay stable while REQ[SEL] stays high. Stall cycles do not advance idle_cnt.
- Reset mid-burst: the next edge forces the reset values; no partial beat is counted.
- Single-beat burst (LAST high on first beat) is legal: GRANT lasts exactly one cycle if READY=1.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=1'b0, GRANT=1'b1).
  - 2-bit requester index width constant.
  - onehot/encode helper functions.
- Sub-module mux4_w: parameterized W-bit 4:1 mux (SEL, DIN0..3 -> DOUT), instantiated once.
- Arbiter logic (ptr, FSM, counters) stays in the top level.

Test Plan:
- Reset then REQ=4'b0101, LAST=4'b0101, READY=1. Expected:
  - GNT=0001 at cycle 1 and SEL=0.
  - After DIN0's beat, IDLE for 1 cycle.
  - GNT=0100 at cycle 3, SEL=2, DOUT=DIN2. Then ptr=3.
- All REQ=1111 held, LAST=1 every beat, READY=1. Expected: grants rotate 0001,0010,0100,1000,0001 with one IDLE cycle between each.
- REQ[1]=1, LAST=0, READY=1, MAX_BURST=16. Expected: DOUT_LAST on the 16th beat (beat_cnt=15), release, ptr=2, re-grant to 1 after one IDLE cycle.
- Grant requester 3, then drop REQ[3] for 8 cycles, IDLE_TIMEOUT=8. Expected: GNT=0 on the cycle after idle_cnt=7, no transfer, ptr=0.
- Grant requester 0 with READY=0 for 5 cycles, DIN0=8'hA5. Expected: DOUT=8'hA5 and DOUT_VALID=1 stable, beat_cnt=0, no timeout. Transfer on the first READY=1.
- RST asserted mid-burst at beat_cnt=5. Expected: next cycle GNT=0, SEL=0, BUSY=0, ptr=0. The first grant after reset goes to the lowest requesting index.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-requester round-robin burst arbiter.
// Covers state encoding, the requester index width and one-hot helpers.
package mux4_rr_arbiter_pkg;

   localparam int unsigned IDX_W = 2;
   localparam int unsigned N_REQ = 4;

   localparam logic [0:0] STATE_IDLE  = 1'b0;
   localparam logic [0:0] STATE_GRANT = 1'b1;

   function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      onehot = N_REQ'(1) << idx;
   endfunction

   function automatic logic [IDX_W-1:0] encode(input logic [N_REQ-1:0] vec);
      encode = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (vec[i]) encode = IDX_W'(i);
      end
   endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4_w.sv
// Parameterized W-bit 4:1 data mux steered by a 2-bit select.
module mux4_w
   import mux4_rr_arbiter_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic [IDX_W-1:0] SEL,
   input  logic [W-1:0]     DIN0,
   input  logic [W-1:0]     DIN1,
   input  logic [W-1:0]     DIN2,
   input  logic [W-1:0]     DIN3,
   output logic [W-1:0]     DOUT
);

   always_comb begin
      DOUT = DIN0;
      case (SEL)
         2'd1:    DOUT = DIN1;
         2'd2:    DOUT = DIN2;
         2'd3:    DOUT = DIN3;
         default: DOUT = DIN0;
      endcase
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready output channel among four
// producers; a grant is held for a whole burst, capped by MAX_BURST or an idle timeout.
module mux4_rr_arbiter
   import mux4_rr_arbiter_pkg::*;
#(
   parameter int unsigned W            = 8,
   parameter int unsigned MAX_BURST    = 16,
   parameter int unsigned IDLE_TIMEOUT = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [N_REQ-1:0] REQ,
   input  logic [N_REQ-1:0] LAST,
   input  logic [W-1:0]     DIN0,
   input  logic [W-1:0]     DIN1,
   input  logic [W-1:0]     DIN2,
   input  logic [W-1:0]     DIN3,
   output logic [N_REQ-1:0] GNT,
   output logic [IDX_W-1:0] SEL,
   output logic [W-1:0]     DOUT,
   output logic             DOUT_VALID,
   output logic             DOUT_LAST,
   input  logic             DOUT_READY,
   output logic             BUSY
);

   localparam int unsigned BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam int unsigned IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

   logic [0:0]       state, state_d;
   logic [N_REQ-1:0] gnt_d;
   logic [IDX_W-1:0] sel_d;
   logic [IDX_W-1:0] ptr, ptr_d;
   logic [BEAT_W-1:0] beat_cnt, beat_d;
   logic [IDLE_W-1:0] idle_cnt, idle_d;

   logic             granted;
   logic             xfer;
   logic             found;
   logic [IDX_W-1:0] pick;
   logic [IDX_W-1:0] idx;

   mux4_w #(.W(W)) u_mux (
      .SEL  (SEL),
      .DIN0 (DIN0),
      .DIN1 (DIN1),
      .DIN2 (DIN2),
      .DIN3 (DIN3),
      .DOUT (DOUT)
   );

   assign granted    = (state == STATE_GRANT);
   assign BUSY       = granted;
   assign DOUT_VALID = granted & REQ[SEL];
   assign DOUT_LAST  = DOUT_VALID & (LAST[SEL] | (beat_cnt == BEAT_W'(MAX_BURST - 1)));
   assign xfer       = DOUT_VALID & DOUT_READY;

   // Next-state logic: rotating-priority pick in IDLE, burst tracking in GRANT.
   always_comb begin
      state_d = state;
      gnt_d   = GNT;
      sel_d   = SEL;
      ptr_d   = ptr;
      beat_d  = beat_cnt;
      idle_d  = idle_cnt;
      found   = 1'b0;
      pick    = ptr;
      idx     = ptr;

      for (int k = 0; k < N_REQ; k++) begin
         idx = ptr + IDX_W'(k);
         if (!found && REQ[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end

      case (state)
         STATE_IDLE: begin
            beat_d = '0;
            idle_d = '0;
            if (found) begin
               state_d = STATE_GRANT;
               gnt_d   = onehot(pick);
               sel_d   = pick;
            end
         end
         default: begin
            if (xfer && DOUT_LAST) begin
               state_d = STATE_IDLE;
               gnt_d   = '0;
               ptr_d   = SEL + IDX_W'(1);
               beat_d  = '0;
               idle_d  = '0;
            end else if (xfer) begin
               beat_d = beat_cnt + BEAT_W'(1);
               idle_d = '0;
            end else if (!REQ[SEL]) begin
               if (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1)) begin
                  state_d = STATE_IDLE;
                  gnt_d   = '0;
                  ptr_d   = SEL + IDX_W'(1);
                  beat_d  = '0;
                  idle_d  = '0;
               end else begin
                  idle_d = idle_cnt + IDLE_W'(1);
               end
            end else begin
               // Stalled by the consumer while the requester still holds a beat.
               idle_d = '0;
            end
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= STATE_IDLE;
         GNT      <= '0;
         SEL      <= '0;
         ptr      <= '0;
         beat_cnt <= '0;
         idle_cnt <= '0;
      end else begin
         state    <= state_d;
         GNT      <= gnt_d;
         SEL      <= sel_d;
         ptr      <= ptr_d;
         beat_cnt <= beat_d;
         idle_cnt <= idle_d;
      end
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter with hand-computed expectations.
module tb_mux4_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req, last;
   logic [7:0] din0, din1, din2, din3;
   logic       ready;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic [7:0] dout;
   logic       dout_valid, dout_last, busy;

   int n_assert = 0;
   int n_fail   = 0;

   mux4_rr_arbiter #(.W(8), .MAX_BURST(16), .IDLE_TIMEOUT(8)) dut (
      .CLK        (clk),
      .RST        (rst),
      .REQ        (req),
      .LAST       (last),
      .DIN0       (din0),
      .DIN1       (din1),
      .DIN2       (din2),
      .DIN3       (din3),
      .GNT        (gnt),
      .SEL        (sel),
      .DOUT       (dout),
      .DOUT_VALID (dout_valid),
      .DOUT_LAST  (dout_last),
      .DOUT_READY (ready),
      .BUSY       (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; req = 4'b0; last = 4'b0; ready = 1'b1;
      din0 = 8'h11; din1 = 8'h22; din2 = 8'h33; din3 = 8'h44;
      tick(); tick();
      rst = 1'b0;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_valid", 32'(dout_valid), 32'h0);
      chk("rst_last", 32'(dout_last), 32'h0);
      chk("rst_dout", 32'(dout), 32'h11);

      // Two requesters, single-beat bursts
      req = 4'b0101; last = 4'b0101;
      tick();
      chk("t1_gnt0", 32'(gnt), 32'b0001);
      chk("t1_sel0", 32'(sel), 32'd0);
      chk("t1_valid", 32'(dout_valid), 32'h1);
      chk("t1_last", 32'(dout_last), 32'h1);
      chk("t1_dout0", 32'(dout), 32'h11);
      tick();
      chk("t1_idle_gnt", 32'(gnt), 32'h0);
      chk("t1_idle_busy", 32'(busy), 32'h0);
      chk("t1_idle_valid", 32'(dout_valid), 32'h0);
      tick();
      chk("t1_gnt2", 32'(gnt), 32'b0100);
      chk("t1_sel2", 32'(sel), 32'd2);
      chk("t1_dout2", 32'(dout), 32'h33);
      tick();
      chk("t1_rel2", 32'(gnt), 32'h0);
      req = 4'b0000;
      tick();
      req = 4'b1001; last = 4'b1111;
      tick();
      chk("t1_ptr3", 32'(gnt), 32'b1000);
      chk("t1_dout3", 32'(dout), 32'h44);
      tick();
      req = 4'b0000;
      tick();

      // Full contention rotation starting from ptr=0
      req = 4'b1111; last = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         logic [3:0] e;
         e = 4'b0001 << (i % 4);
         tick();
         chk("t2_rot_gnt", 32'(gnt), 32'(e));
         tick();
         chk("t2_rot_idle", 32'(gnt), 32'h0);
      end
      req = 4'b0000;
      tick();

      // Forced release at MAX_BURST (ptr now 1)
      req = 4'b0010; last = 4'b0000;
      tick();
      chk("t3_gnt1", 32'(gnt), 32'b0010);
      for (int b = 0; b < 16; b++) begin
         chk("t3_beat_last", 32'(dout_last), (b == 15) ? 32'h1 : 32'h0);
         tick();
      end
      chk("t3_released", 32'(gnt), 32'h0);
      tick();
      chk("t3_regrant1", 32'(gnt), 32'b0010);
      last = 4'b0010;
      tick();
      req = 4'b0000;
      tick();

      // Idle timeout on requester 3 (ptr now 2)
      req = 4'b1000; last = 4'b0000;
      tick();
      chk("t4_gnt3", 32'(gnt), 32'b1000);
      req = 4'b0000;
      for (int c = 0; c < 7; c++) begin
         tick();
         chk("t4_hold", 32'(gnt), 32'b1000);
         chk("t4_novalid", 32'(dout_valid), 32'h0);
      end
      tick();
      chk("t4_revoked", 32'(gnt), 32'h0);
      req = 4'b1111; last = 4'b1111;
      tick();
      chk("t4_ptr0", 32'(gnt), 32'b0001);
      tick();
      req = 4'b0000;
      tick();

      // Consumer stall on requester 0 (ptr now 1)
      req = 4'b0001; last = 4'b0001; din0 = 8'hA5; ready = 1'b0;
      tick();
      chk("t5_gnt0", 32'(gnt), 32'b0001);
      for (int s = 0; s < 5; s++) begin
         tick();
         chk("t5_dout", 32'(dout), 32'hA5);
         chk("t5_valid", 32'(dout_valid), 32'h1);
         chk("t5_gnt", 32'(gnt), 32'b0001);
      end
      ready = 1'b1;
      chk("t5_last", 32'(dout_last), 32'h1);
      tick();
      chk("t5_xfer", 32'(gnt), 32'h0);
      req = 4'b0000;
      tick();

      // Reset in the middle of a burst (ptr now 1, requester 2 wins)
      req = 4'b0100; last = 4'b0000;
      tick();
      chk("t6_gnt2", 32'(gnt), 32'b0100);
      for (int b = 0; b < 5; b++) tick();
      chk("t6_still", 32'(gnt), 32'b0100);
      rst = 1'b1;
      tick();
      chk("t6_rst_gnt", 32'(gnt), 32'h0);
      chk("t6_rst_sel", 32'(sel), 32'h0);
      chk("t6_rst_busy", 32'(busy), 32'h0);
      chk("t6_rst_valid", 32'(dout_valid), 32'h0);
      rst = 1'b0;
      req = 4'b1010;
      tick();
      chk("t6_lowest", 32'(gnt), 32'b0010);
      chk("t6_sel", 32'(sel), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
